// File: rtl/id_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_operand_stage
// Description : ID-stage pipeline register and source-operand resolver.
//               Holds one decoded instruction between IF and EXE. It resolves
//               both source operands with the priority EXE > MEM > WB >
//               register file. It stalls while the winning producer's data is
//               not yet final. Operands and payload go to EXE under a
//               valid/allowin handshake. The operands are frozen in hold
//               registers while EXE back-pressures.
// Ports       : clk, resetn (sync, active low), flush
//               fs_*        : instruction offered by IF
//               ds_allowin  : ID can accept this cycle
//               rf_raddr*/rf_rdata* : combinational register-file read
//               {exe,mem,wb}_* : bypass information of each later stage
//               es_allowin  : EXE accepts this cycle
//               ds_to_es_valid, ds_payload, rj_value, rk_value : to EXE
//               stall_cnt   : saturating count of cycles spent stalled
// Revision    : 1.0 - initial release
// ============================================================================
module id_operand_stage #(
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 fs_valid,
    input  logic [PAYLOAD_W-1:0] fs_payload,
    input  logic [4:0]           fs_rj,
    input  logic [4:0]           fs_rk,
    input  logic                 fs_rj_used,
    input  logic                 fs_rk_used,
    output logic                 ds_allowin,
    output logic [4:0]           rf_raddr1,
    output logic [4:0]           rf_raddr2,
    input  logic [31:0]          rf_rdata1,
    input  logic [31:0]          rf_rdata2,
    input  logic [4:0]           exe_w_addr,
    input  logic [4:0]           mem_w_addr,
    input  logic [4:0]           wb_w_addr,
    input  logic [31:0]          exe_w_data,
    input  logic [31:0]          mem_w_data,
    input  logic [31:0]          wb_w_data,
    input  logic                 exe_data_valid,
    input  logic                 mem_data_valid,
    input  logic                 wb_data_valid,
    input  logic                 exe_valid,
    input  logic                 mem_valid,
    input  logic                 wb_valid,
    input  logic                 exe_wen,
    input  logic                 mem_wen,
    input  logic                 wb_wen,
    input  logic                 es_allowin,
    output logic                 ds_to_es_valid,
    output logic [PAYLOAD_W-1:0] ds_payload,
    output logic [31:0]          rj_value,
    output logic [31:0]          rk_value,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_ready = 2'd2;
    localparam logic [1:0] c_st_hold  = 2'd3;

    logic [1:0]           r_state;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [4:0]           r_rj;
    logic [4:0]           r_rk;
    logic                 r_rj_used;
    logic                 r_rk_used;
    logic [31:0]          r_hold_rj;
    logic [31:0]          r_hold_rk;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic [1:0]  w_state;
    logic [2:0]  w_rj_hit;
    logic [2:0]  w_rk_hit;
    logic [2:0]  w_dv;
    logic [32:0] w_rj_res;
    logic [32:0] w_rk_res;
    logic        w_hazard;
    logic        w_capture;
    logic        w_transfer;

    // A stage is a producer for an operand only if it is live, writes the
    // register file, targets the same nonzero register, and the operand is read.
    function automatic logic stage_match(
        input logic       v,
        input logic       wen,
        input logic [4:0] waddr,
        input logic [4:0] addr,
        input logic       used
    );
        return v && wen && (waddr == addr) && (addr != 5'd0) && used;
    endfunction

    // Returns {unresolved, value}. Only the highest-priority hit is consulted.
    // If that hit's data is not final, the operand stays unresolved even when
    // a lower stage holds final data for the same register.
    function automatic logic [32:0] resolve_operand(
        input logic [2:0]  hit,
        input logic [2:0]  dv,
        input logic [31:0] d_exe,
        input logic [31:0] d_mem,
        input logic [31:0] d_wb,
        input logic [31:0] rf_data,
        input logic        is_zero
    );
        logic [32:0] res;
        res = {1'b0, rf_data};
        if (is_zero) begin
            res = 33'd0;
        end else if (hit[0]) begin
            res = dv[0] ? {1'b0, d_exe} : {1'b1, 32'd0};
        end else if (hit[1]) begin
            res = dv[1] ? {1'b0, d_mem} : {1'b1, 32'd0};
        end else if (hit[2]) begin
            res = dv[2] ? {1'b0, d_wb} : {1'b1, 32'd0};
        end
        return res;
    endfunction

    always_comb begin
        w_dv     = {wb_data_valid, mem_data_valid, exe_data_valid};
        w_rj_hit = {stage_match(wb_valid,  wb_wen,  wb_w_addr,  r_rj, r_rj_used),
                    stage_match(mem_valid, mem_wen, mem_w_addr, r_rj, r_rj_used),
                    stage_match(exe_valid, exe_wen, exe_w_addr, r_rj, r_rj_used)};
        w_rk_hit = {stage_match(wb_valid,  wb_wen,  wb_w_addr,  r_rk, r_rk_used),
                    stage_match(mem_valid, mem_wen, mem_w_addr, r_rk, r_rk_used),
                    stage_match(exe_valid, exe_wen, exe_w_addr, r_rk, r_rk_used)};
        w_rj_res = resolve_operand(w_rj_hit, w_dv, exe_w_data, mem_w_data,
                                   wb_w_data, rf_rdata1,
                                   (r_rj == 5'd0) || !r_rj_used);
        w_rk_res = resolve_operand(w_rk_hit, w_dv, exe_w_data, mem_w_data,
                                   wb_w_data, rf_rdata2,
                                   (r_rk == 5'd0) || !r_rk_used);
        w_hazard = w_rj_res[32] || w_rk_res[32];
    end

    // The registered state only records "instruction held and resolving". The
    // WAIT/READY split is re-evaluated every cycle from the current bypass
    // inputs. A captured instruction can therefore be READY in the very next
    // cycle.
    always_comb begin
        w_state = r_state;
        if ((r_state == c_st_wait) || (r_state == c_st_ready)) begin
            w_state = w_hazard ? c_st_wait : c_st_ready;
        end
    end

    assign ds_to_es_valid = (w_state == c_st_ready) || (w_state == c_st_hold);
    assign ds_allowin     = (w_state == c_st_empty) || (ds_to_es_valid && es_allowin);
    assign w_capture      = fs_valid && ds_allowin && !flush;
    assign w_transfer     = ds_to_es_valid && es_allowin;

    assign rf_raddr1  = r_rj;
    assign rf_raddr2  = r_rk;
    assign ds_payload = r_payload;
    assign stall_cnt  = r_stall_cnt;

    always_comb begin
        rj_value = 32'd0;
        rk_value = 32'd0;
        if (w_state == c_st_hold) begin
            rj_value = r_hold_rj;
            rk_value = r_hold_rk;
        end else if (w_state == c_st_ready) begin
            rj_value = w_rj_res[31:0];
            rk_value = w_rk_res[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= c_st_empty;
            r_payload   <= '0;
            r_rj        <= 5'd0;
            r_rk        <= 5'd0;
            r_rj_used   <= 1'b0;
            r_rk_used   <= 1'b0;
            r_hold_rj   <= 32'd0;
            r_hold_rk   <= 32'd0;
            r_stall_cnt <= '0;
        end else begin
            if ((w_state == c_st_wait) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end

            if (flush) begin
                r_state <= c_st_empty;
            end else if (w_capture) begin
                // A new capture replaces any instruction leaving this cycle,
                // so the hold registers never apply to it.
                r_state   <= c_st_ready;
                r_payload <= fs_payload;
                r_rj      <= fs_rj;
                r_rk      <= fs_rk;
                r_rj_used <= fs_rj_used;
                r_rk_used <= fs_rk_used;
            end else if (w_transfer) begin
                r_state <= c_st_empty;
            end else if (w_state == c_st_ready) begin
                // READY without transfer means EXE is back-pressuring: freeze
                // the operands presented this cycle.
                r_state   <= c_st_hold;
                r_hold_rj <= w_rj_res[31:0];
                r_hold_rk <= w_rk_res[31:0];
            end else begin
                r_state <= w_state;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- ID-stage pipeline register and operand resolver.
- Sits between the fetch stage and the execute stage, and consumes the per-stage write-back information published by the bypass network.
- Holds one instruction, resolves its two source operands by priority: EXE, then MEM, then WB, then register file.
- Stalls when a matching producer's data is not yet valid.
- Presents operands to EXE under a valid/allowin handshake, and keeps them stable while EXE back-pressures.

Parameters:
PAYLOAD_W, 64, width of opaque decoded payload (pc, control) carried from IF to EXE
CNT_W, 32, width of saturating stall-cycle counter

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
flush  in  1  kill the instruction held in ID (branch/exception redirect)
fs_valid  in  1  IF has an instruction
fs_payload  in  PAYLOAD_W  opaque payload
fs_rj  in  5  source 1 address
fs_rk  in  5  source 2 address
fs_rj_used  in  1  source 1 is read
fs_rk_used  in  1  source 2 is read
ds_allowin  out  1  ID can accept this cycle
rf_raddr1  out  5  register-file read address 1
rf_raddr2  out  5  register-file read address 2
rf_rdata1  in  32  combinational register-file read data 1
rf_rdata2  in  32  combinational register-file read data 2
exe_w_addr, mem_w_addr, wb_w_addr  in  5 each  destination register of each stage
exe_w_data, mem_w_data, wb_w_data  in  32 each  forwarded data of each stage
exe_data_valid, mem_data_valid, wb_data_valid  in  1 each  forwarded data is final this cycle
exe_valid, mem_valid, wb_valid  in  1 each  stage holds a live instruction
exe_wen, mem_wen, wb_wen  in  1 each  stage writes the register file
es_allowin  in  1  EXE accepts this cycle
ds_to_es_valid  out  1  operands and payload valid to EXE
ds_payload  out  PAYLOAD_W  held payload
rj_value  out  32  resolved operand 1
rk_value  out  32  resolved operand 2
stall_cnt  out  CNT_W  cycles spent in WAIT, saturating

Behaviour:
- Reset (resetn=0 at posedge): state=EMPTY; ds_to_es_valid=0; ds_payload=0; rj_value=0; rk_value=0; stall_cnt=0; internal rj/rk/used registers=0.
- Capture: on posedge with fs_valid && ds_allowin && !flush, latch payload, addresses and used flags.
- rf_raddr1/2 are driven from the latched rj/rk.
- Per-operand match against stage S: S_valid && S_wen && S_w_addr==addr && addr!=0 && used.
- The highest-priority matching stage wins (EXE > MEM > WB).
  - If the winning stage's data_valid=1, the operand is its w_data.
  - If the winning stage's data_valid=0, the operand is unresolved (hazard).
  - A lower stage is never consulted past a higher match.
- No match: operand is rf_rdata. Addr 0 or used=0: operand is 0.
- State machine:
  - EMPTY: no instruction. Go to WAIT or READY on capture, according to hazard evaluation in the following cycle (combinational on the latched operands).
  - WAIT: instruction held, at least one operand unresolved. ds_to_es_valid=0. stall_cnt increments each cycle, saturating at all-ones. Go to READY once both operands resolve.
  - READY: both resolved; ds_to_es_valid=1; rj_value/rk_value follow resolution combinationally.
    - If es_allowin=1: instruction transfers. Go to EMPTY, or stay in WAIT/READY if a new capture occurs the same cycle.
    - If es_allowin=0: latch current rj_value/rk_value into hold registers. Go to HOLD.
  - HOLD: ds_to_es_valid=1; rj_value/rk_value driven from hold registers and frozen regardless of bypass or register-file changes. On es_allowin=1, transfer as in READY.
- Handshake: ds_allowin = (state==EMPTY) || (ds_to_es_valid && es_allowin). This supports back-to-back, one instruction per cycle with no bubble.
- Latency: one cycle from IF acceptance to ds_to_es_valid when there is no hazard.
- flush: synchronous, takes priority over capture and transfer. Next state=EMPTY, ds_to_es_valid=0 next cycle. stall_cnt is not cleared.
- Simultaneous transfer and capture: the new instruction replaces the old, and hold registers are not used for the new one.
- Reset asserted mid-WAIT or mid-HOLD: returns to EMPTY with all outputs at reset values.

Test Plan:
- No hazard: rf_rdata1=0x11, rf_rdata2=0x22, fs_rj=3, fs_rk=4, es_allowin=1 -> one cycle later ds_to_es_valid=1, rj_value=0x11, rk_value=0x22. Back-to-back instructions show no bubble.
- Priority: exe and mem both target r5 with data_valid=1, exe_w_data=0xAAAA, mem_w_data=0xBBBB; ID reads r5 -> rj_value=0xAAAA. Dropping exe_valid -> 0xBBBB. Address 0 match -> 0.
- Load-use: mem targets r7 with mem_data_valid=0 for 2 cycles, ID reads r7 -> WAIT for 2 cycles, ds_to_es_valid=0, stall_cnt=2. On mem_data_valid=1 with data 0x1234 -> READY, rj_value=0x1234.
- Back-pressure: READY with rj_value=0x55, es_allowin=0 for 3 cycles while the bypass value changes to 0x66 -> rj_value stays 0x55, ds_allowin=0. es_allowin=1 -> transfer, ds_allowin=1.
- Flush: flush in WAIT and in HOLD -> ds_to_es_valid=0 next cycle, ds_allowin=1. Flush coincident with fs_valid -> nothing captured.
- Reset: resetn=0 for one cycle during HOLD -> all outputs 0, state EMPTY. stall_cnt forced to all-ones minus 1 with two further stall cycles -> saturates at all-ones.
